axi_res_tbl_arb: RTL

//  Shares one AXI reservation table (clear/set/check request-grant ports) between N_PORTS
//  LR/SC adapter instances. Serialises table operations, at most one forwarded per cycle:

---
 rtl/axi_res_tbl_arb.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_res_tbl_arb.sv
// axi_res_tbl_arb: shares one AXI reservation table between N_PORTS LR/SC adapters.
// One table operation is forwarded per cycle. The order is boosted check, then boosted
// set, then clear, then check, then set. Each class has its own round-robin pointer.
// The table is driven combinationally from the winning port. If the table does not
// grant in the same cycle, the winner is locked until the table grants it.

module axi_res_tbl_arb #(
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned MAX_WAIT       = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [N_PORTS-1:0][AXI_ADDR_WIDTH-1:0]   clr_addr_i,
  input  logic [N_PORTS-1:0]                       clr_req_i,
  output logic [N_PORTS-1:0]                       clr_gnt_o,
  input  logic [N_PORTS-1:0][AXI_ADDR_WIDTH-1:0]   set_addr_i,
  input  logic [N_PORTS-1:0][AXI_ID_WIDTH-1:0]     set_id_i,
  input  logic [N_PORTS-1:0]                       set_req_i,
  output logic [N_PORTS-1:0]                       set_gnt_o,
  input  logic [N_PORTS-1:0][AXI_ADDR_WIDTH-1:0]   check_addr_i,
  input  logic [N_PORTS-1:0][AXI_ID_WIDTH-1:0]     check_id_i,
  input  logic [N_PORTS-1:0]                       check_req_i,
  output logic [N_PORTS-1:0]                       check_gnt_o,
  output logic [N_PORTS-1:0]                       check_res_o,
  output logic [AXI_ADDR_WIDTH-1:0]                tbl_clr_addr_o,
  output logic                                     tbl_clr_req_o,
  input  logic                                     tbl_clr_gnt_i,
  output logic [AXI_ADDR_WIDTH-1:0]                tbl_set_addr_o,
  output logic [AXI_ID_WIDTH-1:0]                  tbl_set_id_o,
  output logic                                     tbl_set_req_o,
  input  logic                                     tbl_set_gnt_i,
  output logic [AXI_ADDR_WIDTH-1:0]                tbl_check_addr_o,
  output logic [AXI_ID_WIDTH-1:0]                  tbl_check_id_o,
  output logic                                     tbl_check_req_o,
  input  logic                                     tbl_check_gnt_i,
  input  logic                                     tbl_check_res_i
);

  localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_CLR = 2'd1, CLS_CHECK = 2'd2, CLS_SET = 2'd3} cls_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e         state_r, state_nxt_s;
  cls_e           lock_cls_r, sel_cls_s;
  logic [PW-1:0]  lock_port_r, sel_port_s;
  logic [PW-1:0]  rr_clr_r, rr_chk_r, rr_set_r;
  logic [PW-1:0]  clr_pick_s, chk_pick_s, set_pick_s;
  logic [CW-1:0]  chk_wait_r, set_wait_r;
  logic [N_PORTS-1:0] sel_oh_s;
  logic           fire_s, chk_boost_s, set_boost_s, chk_fire_s, set_fire_s, lock_s;

  // Return the first requesting port at or after ptr. The search wraps from the last port to port 0.
  function automatic logic [PW-1:0] rr_pick(input logic [N_PORTS-1:0] req, input logic [PW-1:0] ptr);
    logic [2*N_PORTS-1:0] win;
    logic [PW-1:0]        sel;
    logic                 found;
    win   = {req, req} >> ptr;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (!found && win[0]) begin
        sel   = PW'((32'(ptr) + k) % N_PORTS);
        found = 1'b1;
      end
      win = win >> 1;
    end
    return sel;
  endfunction

  // Return the pointer value that follows a grant to port: (port + 1) mod N_PORTS.
  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] port);
    if (32'(port) + 32'd1 >= N_PORTS) begin
      return '0;
    end else begin
      return port + PW'(1);
    end
  endfunction

  assign clr_pick_s  = rr_pick(clr_req_i, rr_clr_r);
  assign chk_pick_s  = rr_pick(check_req_i, rr_chk_r);
  assign set_pick_s  = rr_pick(set_req_i, rr_set_r);
  assign chk_boost_s = (chk_wait_r == WAIT_MAX) && (|check_req_i);
  assign set_boost_s = (set_wait_r == WAIT_MAX) && (|set_req_i);
  assign sel_oh_s    = N_PORTS'(1'b1) << sel_port_s;
  assign chk_fire_s  = fire_s && (sel_cls_s == CLS_CHECK);
  assign set_fire_s  = fire_s && (sel_cls_s == CLS_SET);
  assign lock_s      = (state_r == ST_IDLE) && (sel_cls_s != CLS_NONE) && !fire_s;

  // Choose the class and port to forward. In LOCKED this is the latched winner. Reset forces no selection.
  always_comb begin
    sel_cls_s  = CLS_NONE;
    sel_port_s = '0;
    if (!rst_ni) begin
      sel_cls_s = CLS_NONE;
    end else if (state_r == ST_LOCKED) begin
      sel_cls_s  = lock_cls_r;
      sel_port_s = lock_port_r;
    end else if (chk_boost_s) begin
      sel_cls_s  = CLS_CHECK;
      sel_port_s = chk_pick_s;
    end else if (set_boost_s) begin
      sel_cls_s  = CLS_SET;
      sel_port_s = set_pick_s;
    end else if (|clr_req_i) begin
      sel_cls_s  = CLS_CLR;
      sel_port_s = clr_pick_s;
    end else if (|check_req_i) begin
      sel_cls_s  = CLS_CHECK;
      sel_port_s = chk_pick_s;
    end else if (|set_req_i) begin
      sel_cls_s  = CLS_SET;
      sel_port_s = set_pick_s;
    end else begin
      sel_cls_s = CLS_NONE;
    end
  end

  // Drive the selected table port. When the table grants, return the grant to the selected port.
  always_comb begin
    tbl_clr_addr_o   = '0;
    tbl_clr_req_o    = 1'b0;
    tbl_set_addr_o   = '0;
    tbl_set_id_o     = '0;
    tbl_set_req_o    = 1'b0;
    tbl_check_addr_o = '0;
    tbl_check_id_o   = '0;
    tbl_check_req_o  = 1'b0;
    clr_gnt_o        = '0;
    set_gnt_o        = '0;
    check_gnt_o      = '0;
    check_res_o      = '0;
    fire_s           = 1'b0;
    case (sel_cls_s)
      CLS_CLR: begin
        tbl_clr_req_o  = 1'b1;
        tbl_clr_addr_o = clr_addr_i[sel_port_s];
        fire_s         = tbl_clr_gnt_i;
        clr_gnt_o      = tbl_clr_gnt_i ? sel_oh_s : '0;
      end
      CLS_SET: begin
        tbl_set_req_o  = 1'b1;
        tbl_set_addr_o = set_addr_i[sel_port_s];
        tbl_set_id_o   = set_id_i[sel_port_s];
        fire_s         = tbl_set_gnt_i;
        set_gnt_o      = tbl_set_gnt_i ? sel_oh_s : '0;
      end
      CLS_CHECK: begin
        tbl_check_req_o  = 1'b1;
        tbl_check_addr_o = check_addr_i[sel_port_s];
        tbl_check_id_o   = check_id_i[sel_port_s];
        fire_s           = tbl_check_gnt_i;
        check_gnt_o      = tbl_check_gnt_i ? sel_oh_s : '0;
        check_res_o      = (tbl_check_gnt_i && tbl_check_res_i) ? sel_oh_s : '0;
      end
      default: begin
        fire_s = 1'b0;
      end
    endcase
  end

  // Next state: enter LOCKED when a forwarded operation is not granted; leave LOCKED on its grant.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = lock_s ? ST_LOCKED : ST_IDLE;
      ST_LOCKED: state_nxt_s = fire_s ? ST_IDLE : ST_LOCKED;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch the winner that must be held until the table grants it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_cls_r  <= CLS_NONE;
      lock_port_r <= '0;
    end else if (lock_s) begin
      lock_cls_r  <= sel_cls_s;
      lock_port_r <= sel_port_s;
    end else begin
      lock_cls_r  <= lock_cls_r;
      lock_port_r <= lock_port_r;
    end
  end

  // Advance the granted class's round-robin pointer past the port that was just served.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_clr_r <= '0;
      rr_chk_r <= '0;
      rr_set_r <= '0;
    end else if (fire_s) begin
      case (sel_cls_s)
        CLS_CLR:   rr_clr_r <= rr_next(sel_port_s);
        CLS_CHECK: rr_chk_r <= rr_next(sel_port_s);
        CLS_SET:   rr_set_r <= rr_next(sel_port_s);
        default:   rr_clr_r <= rr_clr_r;
      endcase
    end else begin
      rr_clr_r <= rr_clr_r;
    end
  end

  // Starvation counters for check and set, kept in every state. They saturate at MAX_WAIT and clear on grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_wait_r <= '0;
      set_wait_r <= '0;
    end else begin
      if (chk_fire_s) begin
        chk_wait_r <= '0;
      end else if ((|check_req_i) && (chk_wait_r != WAIT_MAX)) begin
        chk_wait_r <= chk_wait_r + CW'(1);
      end else begin
        chk_wait_r <= chk_wait_r;
      end
      if (set_fire_s) begin
        set_wait_r <= '0;
      end else if ((|set_req_i) && (set_wait_r != WAIT_MAX)) begin
        set_wait_r <= set_wait_r + CW'(1);
      end else begin
        set_wait_r <= set_wait_r;
      end
    end
  end

  axi_res_tbl_arb_chk #(.N_PORTS(N_PORTS)) u_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_req_i   (clr_req_i),
    .clr_gnt_i   (clr_gnt_o),
    .set_req_i   (set_req_i),
    .set_gnt_i   (set_gnt_o),
    .check_req_i (check_req_i),
    .check_gnt_i (check_gnt_o)
  );

endmodule

// axi_res_tbl_arb_chk: requester-side protocol checks. A request must stay high until it is granted.
module axi_res_tbl_arb_chk #(
  parameter int unsigned N_PORTS = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  input logic [N_PORTS-1:0] clr_req_i,
  input logic [N_PORTS-1:0] clr_gnt_i,
  input logic [N_PORTS-1:0] set_req_i,
  input logic [N_PORTS-1:0] set_gnt_i,
  input logic [N_PORTS-1:0] check_req_i,
  input logic [N_PORTS-1:0] check_gnt_i
);
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    a_clr_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      clr_req_i[p] && !clr_gnt_i[p] |=> clr_req_i[p]);
    a_set_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      set_req_i[p] && !set_gnt_i[p] |=> set_req_i[p]);
    a_chk_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      check_req_i[p] && !check_gnt_i[p] |=> check_req_i[p]);
  end
endmodule
